imm_extend_pipe: RTL

Pipelined, parametrised immediate/target generator for the IF/ID boundary of the 5-stage MIPS core. It accepts a raw instruction word, PC+4 and an extension mode, then produces the extended immediate and, for branch/jump modes, the resolved control-flow target. The block registers its results behind a valid/ready handshake with flush, so it can sit directly in the decode pipeline register path and absorb hazard stalls. It replaces the purely combinational sign extender.

---
 rtl/mips_pkg.sv | 16 +
 rtl/imm_extend_core.sv | 53 +++++
 rtl/imm_extend_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: immediate-extension mode encodings and default datapath widths.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMM_W_DEF  = 16;
  localparam int JMP_W_DEF  = 26;

  typedef enum logic [2:0] {
    IMM_SEXT   = 3'd0,
    IMM_ZEXT   = 3'd1,
    IMM_LUI    = 3'd2,
    IMM_BRANCH = 3'd3,
    IMM_JUMP   = 3'd4
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate mode mux: extended immediate plus control-flow and reserved-mode flags.
module imm_extend_core
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int JMP_W  = JMP_W_DEF
) (
  input  logic [31:0]       instr,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] imm,
  output logic              is_cf,
  output logic              err
);

  localparam int FIELD_W = (IMM_W > JMP_W) ? IMM_W : JMP_W;

  logic [DATA_W-1:0] sext_s;
  logic [DATA_W-1:0] zext_s;
  logic [DATA_W-1:0] jump_s;

  assign sext_s = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign zext_s = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  assign jump_s = {{(DATA_W-JMP_W-2){1'b0}}, instr[JMP_W-1:0], 2'b00};

  // Opcode/register bits above the immediate and jump fields are not needed here.
  if (FIELD_W < 32) begin : g_unused
    logic unused_hi_s;
    assign unused_hi_s = ^instr[31:FIELD_W];
  end

  // Mode mux; LUI is the sign-extended field shifted up, which equals s({imm, 0}) since DATA_W >= 2*IMM_W.
  always_comb begin
    imm   = {DATA_W{1'b0}};
    is_cf = 1'b0;
    err   = 1'b0;
    case (mode)
      IMM_SEXT:   imm = sext_s;
      IMM_ZEXT:   imm = zext_s;
      IMM_LUI:    imm = sext_s << IMM_W;
      IMM_BRANCH: begin
        imm   = sext_s << 2;
        is_cf = 1'b1;
      end
      IMM_JUMP:   begin
        imm   = jump_s;
        is_cf = 1'b1;
      end
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate/target generator for the IF/ID boundary, valid/ready handshake with flush.
// STAGES=1 registers the full result; STAGES=2 splits extension and target generation.
module imm_extend_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int JMP_W  = JMP_W_DEF,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] target_out,
  output logic              is_cf,
  output logic              err,
  output logic [15:0]       err_count
);

  if (DATA_W < 2*IMM_W || DATA_W <= JMP_W+2) begin : g_bad_width
    $error("imm_extend_pipe: DATA_W too small for IMM_W/JMP_W");
  end

  logic [DATA_W-1:0] core_imm_s;
  logic              core_cf_s;
  logic              core_err_s;
  logic              is_br_s;
  logic              is_jmp_s;
  logic              in_ready_s;
  logic              accept_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] imm_r;
  logic [DATA_W-1:0] target_r;
  logic              is_cf_r;
  logic              err_r;
  logic [15:0]       err_count_r;

  imm_extend_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .JMP_W  (JMP_W)
  ) u_core (
    .instr (instr),
    .mode  (mode),
    .imm   (core_imm_s),
    .is_cf (core_cf_s),
    .err   (core_err_s)
  );

  assign is_br_s  = (mode == IMM_BRANCH);
  assign is_jmp_s = (mode == IMM_JUMP);
  assign accept_s = in_valid && in_ready_s && !flush;

  function automatic logic [DATA_W-1:0] calc_target(
    input logic              br,
    input logic              jmp,
    input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] imm,
    input logic [JMP_W-1:0]  idx
  );
    logic [DATA_W-1:0] t;
    if (br) begin
      t = pc + imm;
    end else if (jmp) begin
      t = {pc[DATA_W-1:JMP_W+2], idx, 2'b00};
    end else begin
      t = {DATA_W{1'b0}};
    end
    return t;
  endfunction

  if (STAGES == 1) begin : g_one
    assign in_ready_s = !out_valid_r || out_ready;

    // Single output register: flush beats everything, otherwise load whenever the slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_r <= 1'b0;
        imm_r       <= {DATA_W{1'b0}};
        target_r    <= {DATA_W{1'b0}};
        is_cf_r     <= 1'b0;
        err_r       <= 1'b0;
      end else if (flush) begin
        out_valid_r <= 1'b0;
      end else if (in_ready_s) begin
        out_valid_r <= in_valid;
        if (in_valid) begin
          imm_r    <= core_imm_s;
          target_r <= calc_target(is_br_s, is_jmp_s, pc_plus4, core_imm_s, instr[JMP_W-1:0]);
          is_cf_r  <= core_cf_s;
          err_r    <= core_err_s;
        end
      end
    end
  end else if (STAGES == 2) begin : g_two
    logic              v1_r;
    logic [DATA_W-1:0] imm1_r;
    logic [DATA_W-1:0] pc1_r;
    logic [JMP_W-1:0]  jidx1_r;
    logic              cf1_r;
    logic              err1_r;
    logic              br1_r;
    logic              jmp1_r;
    logic              ready2_s;

    assign ready2_s   = !out_valid_r || out_ready;
    assign in_ready_s = !v1_r || ready2_s;

    // Stage 1: extended immediate, mode flags, PC+4 and jump index.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_r    <= 1'b0;
        imm1_r  <= {DATA_W{1'b0}};
        pc1_r   <= {DATA_W{1'b0}};
        jidx1_r <= {JMP_W{1'b0}};
        cf1_r   <= 1'b0;
        err1_r  <= 1'b0;
        br1_r   <= 1'b0;
        jmp1_r  <= 1'b0;
      end else if (flush) begin
        v1_r <= 1'b0;
      end else if (in_ready_s) begin
        v1_r <= in_valid;
        if (in_valid) begin
          imm1_r  <= core_imm_s;
          pc1_r   <= pc_plus4;
          jidx1_r <= instr[JMP_W-1:0];
          cf1_r   <= core_cf_s;
          err1_r  <= core_err_s;
          br1_r   <= is_br_s;
          jmp1_r  <= is_jmp_s;
        end
      end
    end

    // Stage 2: target add / jump concatenation into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_r <= 1'b0;
        imm_r       <= {DATA_W{1'b0}};
        target_r    <= {DATA_W{1'b0}};
        is_cf_r     <= 1'b0;
        err_r       <= 1'b0;
      end else if (flush) begin
        out_valid_r <= 1'b0;
      end else if (ready2_s) begin
        out_valid_r <= v1_r;
        if (v1_r) begin
          imm_r    <= imm1_r;
          target_r <= calc_target(br1_r, jmp1_r, pc1_r, imm1_r, jidx1_r);
          is_cf_r  <= cf1_r;
          err_r    <= err1_r;
        end
      end
    end
  end else begin : g_bad_stages
    $error("imm_extend_pipe: STAGES must be 1 or 2");
  end

  // Saturating count of reserved-mode entries at the moment they are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 16'h0000;
    end else if (accept_s && core_err_s && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign imm_out    = imm_r;
  assign target_out = target_r;
  assign is_cf      = is_cf_r;
  assign err        = err_r;
  assign err_count  = err_count_r;

endmodule
